imem_responder: RTL and testbench

Memory-side responder for the instruction-cache miss path: accepts one-word read requests from the icache controller, stalls further requests while busy, and returns the addressed word after a fixed, parameterised latency with a one-cycle valid strobe. It owns a word-addressed instruction store. A side load port fills that store at boot or from the testbench. It sits directly behind the icache controller's MEM_* ports.

---
 rtl/imem_responder_pkg.sv | 18 +
 rtl/imem_responder_if.sv | 30 +++
 rtl/imem_responder_storage.sv | 27 ++
 rtl/imem_responder.sv | 105 ++++++++++
 tb/tb_imem_responder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Holds the FSM state encoding and the latency counter width.
package imem_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT    = 2'b01,
        RESPOND = 2'b10
    } state_e;

    // The counter holds the number of WAIT cycles still to spend after acceptance.
    function automatic logic [CNT_W-1:0] waitCycles(input int latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Read-request bus between the icache controller (master) and the
// instruction-memory responder (slave).
interface imem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                  MEM_READ_REQ;
    logic [ADDR_WIDTH-1:0] MEM_ADDRESS;
    logic                  MEM_BUSYWAIT;
    logic [DATA_WIDTH-1:0] MEM_READDATA;
    logic                  MEM_READDATA_VALID;

    modport master (
        output MEM_READ_REQ,
        output MEM_ADDRESS,
        input  MEM_BUSYWAIT,
        input  MEM_READDATA,
        input  MEM_READDATA_VALID
    );

    modport slave (
        input  MEM_READ_REQ,
        input  MEM_ADDRESS,
        output MEM_BUSYWAIT,
        output MEM_READDATA,
        output MEM_READDATA_VALID
    );

endinterface

// File: rtl/imem_responder_storage.sv
// Word-addressed instruction store: clocked write port, asynchronous read port.
// A read sampled on the same edge as a write to that index sees the old word.
module imem_storage #(
    parameter int MEM_AW     = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  wrEn_i,
    input  logic [MEM_AW-1:0]     wrAddr_i,
    input  logic [DATA_WIDTH-1:0] wrData_i,
    input  logic [MEM_AW-1:0]     rdAddr_i,
    output logic [DATA_WIDTH-1:0] rdData_o
);

    localparam int DEPTH = 2 ** MEM_AW;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/imem_responder.sv
// Memory-side responder for the icache miss path: accepts one read at a time,
// returns the addressed word after LATENCY edges with a one-cycle valid strobe.
module imem_responder
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 10,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_responder_if.slave       mem,
    input  logic                  LOAD_EN,
    input  logic [MEM_AW-1:0]     LOAD_ADDR,
    input  logic [DATA_WIDTH-1:0] LOAD_DATA
);

    if (LATENCY < 1 || LATENCY > 255) begin : gLatencyCheck
        $error("imem_responder: LATENCY must be in 1..255");
    end

    localparam logic [CNT_W-1:0] WAIT_CYCLES = waitCycles(LATENCY);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [MEM_AW-1:0]     idx_q, idx_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [MEM_AW-1:0]     reqIdx;
    logic [MEM_AW-1:0]     rdIdx;
    logic [DATA_WIDTH-1:0] storeData;
    logic                  unusedAddrHi;

    // Upper address bits alias onto the same word.
    assign reqIdx       = mem.MEM_ADDRESS[MEM_AW-1:0];
    assign unusedAddrHi = ^mem.MEM_ADDRESS;
    assign rdIdx        = (state_q == WAIT) ? idx_q : reqIdx;

    imem_storage #(
        .MEM_AW     (MEM_AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_storage (
        .clk      (clk),
        .wrEn_i   (LOAD_EN),
        .wrAddr_i (LOAD_ADDR),
        .wrData_i (LOAD_DATA),
        .rdAddr_i (rdIdx),
        .rdData_o (storeData)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        case (state_q)
            WAIT: begin
                // Zero-guarded so the counter can never wrap.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    rdata_d = storeData;
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                if (mem.MEM_READ_REQ) begin
                    idx_d = reqIdx;
                    // With no WAIT cycles the word is captured on the acceptance edge.
                    if (WAIT_CYCLES == '0) begin
                        rdata_d = storeData;
                        state_d = RESPOND;
                    end else begin
                        cnt_d   = WAIT_CYCLES;
                        state_d = WAIT;
                    end
                end
            end
        endcase
    end

    assign mem.MEM_BUSYWAIT       = (state_q == WAIT) || (state_q == RESPOND);
    assign mem.MEM_READDATA_VALID = (state_q == RESPOND);
    assign mem.MEM_READDATA       = rdata_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a LATENCY=4 instance driven from a vector
// table and a LATENCY=1 instance for back-to-back reads, plus reset abort.
module tb_imem_responder;

    logic        clk;
    logic        reset;
    logic        loadEn;
    logic [9:0]  loadAddr;
    logic [31:0] loadData;

    int total;
    int bad;

    imem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus4 ();
    imem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

    imem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(10), .LATENCY(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .mem       (bus4),
        .LOAD_EN   (loadEn),
        .LOAD_ADDR (loadAddr),
        .LOAD_DATA (loadData)
    );

    imem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(10), .LATENCY(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .mem       (bus1),
        .LOAD_EN   (loadEn),
        .LOAD_ADDR (loadAddr),
        .LOAD_DATA (loadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        ldEn;
        logic [9:0]  ldAddr;
        logic [31:0] ldData;
        logic        expBusy;
        logic        expValid;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic req, input logic [31:0] addr, input logic ldEn,
                          input logic [9:0] ldAddr, input logic [31:0] ldData,
                          input logic expBusy, input logic expValid, input logic [31:0] expData);
        vec_t v;
        v.req      = req;
        v.addr     = addr;
        v.ldEn     = ldEn;
        v.ldAddr   = ldAddr;
        v.ldData   = ldData;
        v.expBusy  = expBusy;
        v.expValid = expValid;
        v.expData  = expData;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus4.MEM_READ_REQ = v.req;
        bus4.MEM_ADDRESS  = v.addr;
        loadEn            = v.ldEn;
        loadAddr          = v.ldAddr;
        loadData          = v.ldData;
    endtask

    task automatic loadWord(input logic [9:0] a, input logic [31:0] d);
        loadEn   = 1'b1;
        loadAddr = a;
        loadData = d;
        @(posedge clk);
        #1;
        loadEn = 1'b0;
    endtask

    task automatic check4(input string tag, input logic busy, input logic valid, input logic [31:0] data);
        checkOutput({tag, " busy4"},  {31'd0, bus4.MEM_BUSYWAIT},       {31'd0, busy});
        checkOutput({tag, " valid4"}, {31'd0, bus4.MEM_READDATA_VALID}, {31'd0, valid});
        checkOutput({tag, " data4"},  bus4.MEM_READDATA,                data);
    endtask

    task automatic check1(input string tag, input logic busy, input logic valid, input logic [31:0] data);
        checkOutput({tag, " busy1"},  {31'd0, bus1.MEM_BUSYWAIT},       {31'd0, busy});
        checkOutput({tag, " valid1"}, {31'd0, bus1.MEM_READDATA_VALID}, {31'd0, valid});
        checkOutput({tag, " data1"},  bus1.MEM_READDATA,                data);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        loadEn = 1'b0;
        loadAddr = '0;
        loadData = '0;
        bus4.MEM_READ_REQ = 1'b0;
        bus4.MEM_ADDRESS  = '0;
        bus1.MEM_READ_REQ = 1'b0;
        bus1.MEM_ADDRESS  = '0;

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        #1;
        check4("reset", 1'b0, 1'b0, 32'h0);
        check1("reset", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        loadWord(10'd5,  32'hDEAD_BEEF);
        loadWord(10'd1,  32'hA1A1_A1A1);
        loadWord(10'd2,  32'hA2A2_A2A2);
        loadWord(10'd3,  32'hA3A3_A3A3);
        loadWord(10'd7,  32'h2222_2222);
        loadWord(10'd9,  32'h9999_9999);
        loadWord(10'd10, 32'h1010_1010);

        // Single read of index 5, then hold-after-response.
        addVec(1, 32'd5,     0, 0, 0, 1, 0, 32'h0);
        addVec(0, 32'd0,     0, 0, 0, 1, 0, 32'h0);
        addVec(0, 32'd0,     0, 0, 0, 1, 0, 32'h0);
        addVec(0, 32'd0,     0, 0, 0, 1, 1, 32'hDEAD_BEEF);
        addVec(0, 32'd0,     0, 0, 0, 0, 0, 32'hDEAD_BEEF);
        addVec(0, 32'd0,     0, 0, 0, 0, 0, 32'hDEAD_BEEF);
        // Read of 9, with a request to 0x405 held while busy; it aliases to 5.
        addVec(1, 32'd9,     0, 0, 0, 1, 0, 32'hDEAD_BEEF);
        addVec(1, 32'h405,   0, 0, 0, 1, 0, 32'hDEAD_BEEF);
        addVec(1, 32'h405,   0, 0, 0, 1, 0, 32'hDEAD_BEEF);
        addVec(1, 32'h405,   0, 0, 0, 1, 1, 32'h9999_9999);
        addVec(1, 32'h405,   0, 0, 0, 0, 0, 32'h9999_9999);
        addVec(1, 32'h405,   0, 0, 0, 1, 0, 32'h9999_9999);
        addVec(0, 32'd0,     0, 0, 0, 1, 0, 32'h9999_9999);
        addVec(0, 32'd0,     0, 0, 0, 1, 0, 32'h9999_9999);
        addVec(0, 32'd0,     0, 0, 0, 1, 1, 32'hDEAD_BEEF);
        addVec(0, 32'd0,     0, 0, 0, 0, 0, 32'hDEAD_BEEF);
        // Load to index 7 on the capture edge returns the old word.
        addVec(1, 32'd7,     0, 0, 0, 1, 0, 32'hDEAD_BEEF);
        addVec(0, 32'd0,     0, 0, 0, 1, 0, 32'hDEAD_BEEF);
        addVec(0, 32'd0,     0, 0, 0, 1, 0, 32'hDEAD_BEEF);
        addVec(0, 32'd0,     1, 10'd7, 32'h1111_1111, 1, 1, 32'h2222_2222);
        addVec(0, 32'd0,     0, 0, 0, 0, 0, 32'h2222_2222);
        addVec(1, 32'd7,     0, 0, 0, 1, 0, 32'h2222_2222);
        addVec(0, 32'd0,     0, 0, 0, 1, 0, 32'h2222_2222);
        addVec(0, 32'd0,     0, 0, 0, 1, 0, 32'h2222_2222);
        addVec(0, 32'd0,     0, 0, 0, 1, 1, 32'h1111_1111);
        addVec(0, 32'd0,     0, 0, 0, 0, 0, 32'h1111_1111);
        // Address moves from 9 to 10 after acceptance; response is still word 9.
        addVec(1, 32'd9,     0, 0, 0, 1, 0, 32'h1111_1111);
        addVec(0, 32'd10,    0, 0, 0, 1, 0, 32'h1111_1111);
        addVec(0, 32'd10,    0, 0, 0, 1, 0, 32'h1111_1111);
        addVec(0, 32'd10,    0, 0, 0, 1, 1, 32'h9999_9999);
        addVec(0, 32'd10,    0, 0, 0, 0, 0, 32'h9999_9999);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            check4($sformatf("vec%0d", i), vecs[i].expBusy, vecs[i].expValid, vecs[i].expData);
        end
        applyStimulus('{1'b0, 32'd0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 32'd0});

        // LATENCY=1 with the request held: a response every second cycle.
        bus1.MEM_READ_REQ = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            logic [31:0] word;
            word = {4{4'hA, 4'(k)}};
            bus1.MEM_ADDRESS = 32'(k);
            @(posedge clk);
            #1;
            check1($sformatf("b2b%0d resp", k), 1'b1, 1'b1, word);
            @(posedge clk);
            #1;
            check1($sformatf("b2b%0d idle", k), 1'b0, 1'b0, word);
        end
        bus1.MEM_READ_REQ = 1'b0;

        // Reset during WAIT aborts the read; a request is taken right after release.
        bus4.MEM_READ_REQ = 1'b1;
        bus4.MEM_ADDRESS  = 32'd5;
        @(posedge clk);
        #1;
        check4("abort accept", 1'b1, 1'b0, 32'h9999_9999);
        bus4.MEM_READ_REQ = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check4("abort reset", 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus4.MEM_READ_REQ = 1'b1;
        bus4.MEM_ADDRESS  = 32'd3;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            bus4.MEM_READ_REQ = 1'b0;
            check4($sformatf("post-reset e%0d", e), e <= 4, e == 4,
                   (e >= 4) ? 32'hA3A3_A3A3 : 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
